alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one pipelined ALU.
REQ-002 SHALL have parameter W, default 16, ALU operand/result width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pause  input  1  stop granting new requests; in-flight ops complete.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant; handshake = valid & ready.
REQ-008 SHALL have ports req_opcode/req_in1/req_in2/req_shift  input  NREQ*4 / NREQ*W / NREQ*W / NREQ*5  packed per-requester operation fields.
REQ-009 SHALL have ports alu_opcode/alu_in1/alu_in2/alu_shift  output  4 / W / W / 5  drive the shared ALU inputs.
REQ-010 SHALL have ports alu_result  input  W, alu_carry  input  1  shared ALU outputs.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_id  output  clog2(NREQ), rsp_result  output  W, rsp_carry  output  1  response to issuing requester.
REQ-012 SHALL have port busy  output  1  high whenever any operation is in flight.

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin; after grant to i, highest priority moves to (i+1) mod NREQ; no grant leaves pointer unchanged.
REQ-014 req_ready SHALL be combinational from req_valid, pointer, pause and state; req_ready[i] only when req_valid[i]=1.
REQ-015 alu_* outputs SHALL be combinational mux of the granted requester's fields; with no grant they SHALL drive opcode 0, operands 0, shift 0.
REQ-016 SHALL track each issued op with a 2-stage valid/id/opcode pipeline matching ALU latency; rsp_valid SHALL assert exactly 2 cycles after the handshake cycle, for one cycle, no backpressure.
REQ-017 rsp_result SHALL equal alu_result in the rsp_valid cycle; rsp_id SHALL be the granted index.
REQ-018 rsp_carry SHALL equal alu_carry for opcodes 0 (ADD) and 1 (SUB), and 0 for all other opcodes (ALU carry is stale for MUL/SRA).
REQ-019 Opcodes 4-15 SHALL be accepted and return rsp_result 0, rsp_carry 0.
REQ-020 Throughput SHALL be one issue per cycle; back-to-back grants to different requesters SHALL produce back-to-back responses in issue order.
REQ-021 FSM states IDLE, ACTIVE, DRAIN: IDLE->ACTIVE on grant; ACTIVE->IDLE when pipeline empties with no grant; ACTIVE->DRAIN when pause=1 with ops in flight; DRAIN->IDLE when pipeline empty; DRAIN->ACTIVE when pause drops with ops still in flight.
REQ-022 No grant SHALL occur while pause=1; pause asserted same cycle as req_valid SHALL block that request.
REQ-023 busy SHALL equal (state != IDLE); in flight pipeline contents SHALL never be dropped by pause.
REQ-024 When rsp_valid=0, rsp_id, rsp_result, rsp_carry SHALL be 0.

Reset
REQ-025 rst_n low SHALL asynchronously clear pointer to 0, pipeline valids to 0, state to IDLE; rsp_valid, busy, req_ready SHALL read 0 while rst_n low.
REQ-026 Ops in flight at reset assertion SHALL be discarded; no rsp_valid for them after release.
REQ-027 First cycle after release SHALL allow grant, priority starting at requester 0.

Structure
REQ-028 ALU opcode constants (ADD=0, SUB=1, MUL=2, SRA=3), W and NREQ defaults, FSM state enum SHALL live in shared package alu_pkg.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector, pointer, one-hot grant).
REQ-030 ALU SHALL remain external; bench connects the existing 16-bit pipelined ALU, its active-high rst driven by ~rst_n.

Verification
REQ-031 Single: req 2 ADD 0xFFFF+0x0001 -> rsp_valid 2 cycles later, rsp_id 2, result 0x0000, carry 1.
REQ-032 All 4 requesting continuously from reset -> grants 0,1,2,3,0,... one per cycle; responses same order, 2-cycle lag.
REQ-033 Carry mask: SUB 0x0001-0x0002 (carry 1) then MUL 3*5 -> rsp 0xFFFF carry 1, then 0x000F carry 0.
REQ-034 SRA 0x8000 shift 3 by req 1 -> result 0xF000, carry 0; opcode 7 -> result 0, carry 0.
REQ-035 Pause after 2 issues -> no further grants, 2 responses delivered, state DRAIN then IDLE, busy falls after last rsp.
REQ-036 rst_n low 1 cycle after an issue -> no rsp_valid for it; after release first grant to lowest valid index from 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the shared-ALU arbiter: opcodes, default
// sizes and the issue-tracking FSM states.
package alu_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SRA = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Requester index width; a lone requester still gets a 1-bit id.
  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response buses of the arbiter. The master side is
// the environment (requesters plus the external ALU), the slave the arbiter.
interface alu_share_arbiter_if #(
  parameter int NREQ = alu_pkg::NREQ_DEF,
  parameter int W    = alu_pkg::W_DEF
);
  localparam int IDW = alu_pkg::id_w(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][3:0]   req_opcode;
  logic [NREQ-1:0][W-1:0] req_in1;
  logic [NREQ-1:0][W-1:0] req_in2;
  logic [NREQ-1:0][4:0]   req_shift;

  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [4:0]   alu_shift;
  logic [W-1:0] alu_result;
  logic         alu_carry;

  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry;

  modport master (
    output req_valid, req_opcode, req_in1, req_in2, req_shift, alu_result, alu_carry,
    input  req_ready, alu_opcode, alu_in1, alu_in2, alu_shift,
           rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_opcode, req_in1, req_in2, req_shift, alu_result, alu_carry,
    output req_ready, alu_opcode, alu_in1, alu_in2, alu_shift,
           rsp_valid, rsp_id, rsp_result, rsp_carry
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  int idx;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin issue of NREQ requesters onto one external 2-cycle pipelined
// ALU, with an id/opcode shadow pipeline that routes results back.
module alu_share_arbiter import alu_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pause,
  output logic                busy,
  alu_share_arbiter_if.slave  bus
);
  localparam int IDW    = id_w(NREQ);
  localparam int STAGES = 2;

  state_t                    state, state_nxt;
  logic [IDW-1:0]            ptr, gnt_id;
  logic [NREQ-1:0]           req_ok, gnt;
  logic                      fire;
  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1][IDW-1:0]  id_pipe;
  logic [STAGES:1][3:0]      op_pipe;

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign req_ok = bus.req_valid & {NREQ{rst_n & ~pause}};

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (req_ok),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign fire          = |gnt;
  assign bus.req_ready = gnt;

  always_comb begin
    bus.alu_opcode = '0;
    bus.alu_in1    = '0;
    bus.alu_in2    = '0;
    bus.alu_shift  = '0;
    if (fire) begin
      bus.alu_opcode = bus.req_opcode[gnt_id];
      bus.alu_in1    = bus.req_in1[gnt_id];
      bus.alu_in2    = bus.req_in2[gnt_id];
      bus.alu_shift  = bus.req_shift[gnt_id];
    end
  end

  // "Empty" looks one edge ahead: nothing issued now and nothing in stage 1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:            if (fire) state_nxt = ST_ACTIVE;
      ST_ACTIVE, ST_DRAIN:
        if (!fire && !vld_pipe[1]) state_nxt = ST_IDLE;
        else if (pause)            state_nxt = ST_DRAIN;
        else                       state_nxt = ST_ACTIVE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      op_pipe  <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], fire};
      id_pipe  <= {id_pipe[STAGES-1:1], gnt_id};
      op_pipe  <= {op_pipe[STAGES-1:1], bus.alu_opcode};
      if (fire) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // ALU carry is only meaningful for ADD/SUB; undefined opcodes read as zero.
  assign bus.rsp_valid  = vld_pipe[STAGES];
  assign bus.rsp_id     = vld_pipe[STAGES] ? id_pipe[STAGES] : '0;
  assign bus.rsp_result = (vld_pipe[STAGES] && op_pipe[STAGES] <= OP_SRA) ? bus.alu_result : '0;
  assign bus.rsp_carry  = vld_pipe[STAGES] && bus.alu_carry &&
                          (op_pipe[STAGES] == OP_ADD || op_pipe[STAGES] == OP_SUB);
  assign busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic, all
// checked per cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] res;
    logic        c;
  } rsp_t;

  logic clk, rst_n, pause, busy, alu_rst;
  int   checks = 0, failures = 0, cyc = 0, ptr_m = 0;
  rsp_t q[$];

  logic [3:0]  obs_rdy, obs_id;
  logic        obs_rv, obs_c;
  logic [15:0] obs_res;
  state_t      obs_state;

  alu_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pause (pause),
    .busy  (busy),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external 2-stage ALU: carry is left stale on MUL/SRA
  // and undefined opcodes return junk, so the arbiter's masking is exercised.
  logic [W-1:0] a_r1, a_r2;
  logic         a_c1, a_c2;
  assign alu_rst = ~rst_n;
  always_ff @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      a_r1 <= '0; a_r2 <= '0; a_c1 <= 1'b0; a_c2 <= 1'b0;
    end else begin
      case (bus.alu_opcode)
        4'd0: {a_c1, a_r1} <= {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        4'd1: {a_c1, a_r1} <= {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
        4'd2: a_r1 <= W'(bus.alu_in1 * bus.alu_in2);
        4'd3: a_r1 <= W'($signed(bus.alu_in1) >>> bus.alu_shift);
        default: begin a_r1 <= 16'hBEEF; a_c1 <= 1'b1; end
      endcase
      a_r2 <= a_r1;
      a_c2 <= a_c1;
    end
  end
  assign bus.alu_result = a_r2;
  assign bus.alu_carry  = a_c2;

  function automatic logic [16:0] ref_op(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                                         logic [4:0] sh);
    longint s;
    case (op)
      4'd0: begin s = longint'(a) + longint'(b); return {s > 65535, 16'(s)}; end
      4'd1: begin s = longint'(a) - longint'(b); return {a < b, 16'(s)}; end
      4'd2: begin s = longint'(a) * longint'(b); return {1'b0, 16'(s)}; end
      4'd3: begin
        s = a[15] ? longint'(a) - 65536 : longint'(a);
        return {1'b0, 16'(s >>> sh)};
      end
      default: return 17'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model,
  // then return 1 time unit after the next rising edge for new stimulus.
  task automatic step();
    int          g;
    logic [16:0] r;
    rsp_t        e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
    end
    chk("busy", busy, q.size() != 0);
    g = -1;
    if (rst_n && !pause)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    chk("req_ready", bus.req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("alu_opcode", bus.alu_opcode, (g >= 0) ? bus.req_opcode[g] : 4'd0);
    chk("alu_in1", bus.alu_in1, (g >= 0) ? bus.req_in1[g] : 16'd0);
    chk("alu_in2", bus.alu_in2, (g >= 0) ? bus.req_in2[g] : 16'd0);
    chk("alu_shift", bus.alu_shift, (g >= 0) ? bus.req_shift[g] : 5'd0);
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_id", bus.rsp_id, e.id);
      chk("rsp_result", bus.rsp_result, e.res);
      chk("rsp_carry", bus.rsp_carry, e.c);
    end else begin
      chk("rsp_idle", {bus.rsp_valid, bus.rsp_carry, bus.rsp_id, bus.rsp_result}, 0);
    end
    if (g >= 0) begin
      r = ref_op(bus.req_opcode[g], bus.req_in1[g], bus.req_in2[g], bus.req_shift[g]);
      q.push_back('{due: cyc + 2, id: g, res: r[15:0], c: r[16]});
      ptr_m = (g + 1) % NREQ;
    end
    obs_rdy = bus.req_ready; obs_rv = bus.rsp_valid; obs_id = 4'(bus.rsp_id);
    obs_res = bus.rsp_result; obs_c = bus.rsp_carry; obs_state = dut.state;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [3:0] op, logic [15:0] a, logic [15:0] b, logic [4:0] sh);
    bus.req_opcode[i] = op;
    bus.req_in1[i]    = a;
    bus.req_in2[i]    = b;
    bus.req_shift[i]  = sh;
  endtask

  initial begin
    rst_n = 1'b0; pause = 1'b0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, 16'd0, 16'd0, 5'd0);
    #1;
    step(); step();
    chk("reset_ready", obs_rdy, 0);
    rst_n = 1'b1; bus.req_valid = '0;
    step();

    // Single ADD with carry out from requester 2.
    set_req(2, OP_ADD, 16'hFFFF, 16'h0001, 5'd0);
    bus.req_valid = 4'b0100; step();
    bus.req_valid = '0; step(); step();
    chk("add_valid", obs_rv, 1); chk("add_id", obs_id, 2);
    chk("add_res", obs_res, 16'h0000); chk("add_carry", obs_c, 1);

    // SUB with borrow, then MUL whose stale carry must be masked.
    set_req(0, OP_SUB, 16'h0001, 16'h0002, 5'd0);
    set_req(1, OP_MUL, 16'h0003, 16'h0005, 5'd0);
    bus.req_valid = 4'b0011; step();
    bus.req_valid = 4'b0010; step();
    bus.req_valid = '0; step();
    chk("sub_res", obs_res, 16'hFFFF); chk("sub_carry", obs_c, 1);
    step();
    chk("mul_res", obs_res, 16'h000F); chk("mul_carry", obs_c, 0);

    // SRA sign fill, then an undefined opcode.
    set_req(1, OP_SRA, 16'h8000, 16'h0000, 5'd3);
    set_req(3, 4'd7, 16'h1234, 16'h5678, 5'd2);
    bus.req_valid = 4'b0010; step();
    bus.req_valid = 4'b1000; step();
    bus.req_valid = '0; step();
    chk("sra_res", obs_res, 16'hF000); chk("sra_carry", obs_c, 0);
    step();
    chk("op7_valid", obs_rv, 1); chk("op7_res", obs_res, 0); chk("op7_carry", obs_c, 0);

    // Pause after two issues: in-flight ops drain, then idle.
    bus.req_valid = 4'hF; step(); step();
    pause = 1'b1; step();
    chk("pause_rdy", obs_rdy, 0);
    step();
    chk("drain_state", obs_state, ST_DRAIN); chk("drain_rv", obs_rv, 1);
    step();
    chk("idle_state", obs_state, ST_IDLE);
    pause = 1'b0; bus.req_valid = '0; step();

    // All requesting from reset: strict 0,1,2,3 rotation.
    rst_n = 1'b0; bus.req_valid = 4'hF; step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rotate", obs_rdy, 4'b0001 << (k % 4));
    end
    bus.req_valid = '0; step(); step(); step();

    // Reset one cycle after an issue discards it.
    bus.req_valid = 4'b0001; step();
    rst_n = 1'b0; bus.req_valid = '0; step(); step();
    rst_n = 1'b1; bus.req_valid = 4'b1100; step();
    chk("post_rst_gnt", obs_rdy, 4'b0100);
    bus.req_valid = '0; step(); step();
    chk("post_rst_rv", obs_rv, 1); chk("post_rst_id", obs_id, 2);
    step();

    // Random traffic with occasional pause and reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom), 5'($urandom));
      bus.req_valid = 4'($urandom);
      pause = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; pause = 1'b0; bus.req_valid = '0;
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
